// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive dispatcher.
//   ETH_HDR_LEN   : bytes in the Ethernet header (dst, src, EtherType)
//   ETH_BCAST_MAC : broadcast destination address
//   ETYPE_IPV4/ARP: default EtherTypes for the two payload channels
//   rx_byte_t     : {sop, eop, data} word read from the receive FIFO
//   dispatch_state_e : frame sequencer states
package eth_pkg;

    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned ETH_DST_LAST  = 5;
    localparam int unsigned HDR_IDX_W     = 4;
    localparam int unsigned LEN_W         = 11;
    localparam int unsigned MAC_W         = 48;
    // Holds the last 7 header bytes: enough for src MAC plus EtherType high byte.
    localparam int unsigned HDR_SR_W      = 56;

    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETYPE_ARP     = 16'h0806;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } rx_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP
    } dispatch_state_e;

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating statistics counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear to zero, wins over a same-cycle increment
//   inc        : amount to add this cycle (0..3)
//   cnt        : registered count, sticks at all-ones
module eth_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    localparam int unsigned SUM_W = W + 1;

    logic [W-1:0]     cnt_q;
    logic [W-1:0]     cnt_d;
    logic [SUM_W-1:0] sum;

    // Next count: clear, else add with clamp on carry-out.
    always_comb begin
        sum   = {1'b0, cnt_q} + SUM_W'(inc);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (sum[W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/eth_rx_dispatch.sv
// Receive-frame dispatcher: parses the Ethernet header from the RMII FIFO
// readout, filters on destination MAC and steers the payload to the IPv4
// or ARP consumer by EtherType; keeps accept/drop statistics.
//   Clk, Rst_n      : clock, asynchronous active-low reset
//   Recv_Byte       : {SOP, EOP, data[7:0]}, qualified by Recv_Byte_Rdy
//   Mac_Addr/Promisc: station filter, sampled at each SOP
//   Cnt_Clr         : synchronous clear of Acc_Cnt/Drop_Cnt
//   Out_*           : payload stream, one cycle behind the input beat
//   Acc_Cnt/Drop_Cnt: saturating frame statistics
module eth_rx_dispatch
    import eth_pkg::*;
#(
    parameter logic [15:0] pETYPE_CH0 = ETYPE_IPV4,
    parameter logic [15:0] pETYPE_CH1 = ETYPE_ARP,
    parameter int unsigned pCNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [9:0]        Recv_Byte,
    input  logic              Recv_Byte_Rdy,
    input  logic [47:0]       Mac_Addr,
    input  logic              Promisc,
    input  logic              Cnt_Clr,
    output logic [7:0]        Out_Data,
    output logic [1:0]        Out_Vld,
    output logic              Out_Sop,
    output logic              Out_Eop,
    output logic              Out_Abort,
    output logic              Out_Ch,
    output logic [47:0]       Out_Src_Mac,
    output logic [10:0]       Out_Len,
    output logic [pCNT_W-1:0] Acc_Cnt,
    output logic [pCNT_W-1:0] Drop_Cnt
);

    localparam logic [HDR_IDX_W-1:0] IDX_DST_LAST = HDR_IDX_W'(ETH_DST_LAST);
    localparam logic [HDR_IDX_W-1:0] IDX_HDR_LAST = HDR_IDX_W'(ETH_HDR_LEN - 1);

    rx_byte_t rx;
    assign rx = rx_byte_t'(Recv_Byte);

    dispatch_state_e      state_q,       state_d;
    logic [HDR_IDX_W-1:0] idx_q,         idx_d;
    logic [HDR_SR_W-1:0]  hdr_q,         hdr_d;
    logic [MAC_W-1:0]     mac_q,         mac_d;
    logic                 promisc_q,     promisc_d;
    logic [LEN_W-1:0]     len_q,         len_d;
    logic [7:0]           out_data_q,    out_data_d;
    logic [1:0]           out_vld_q,     out_vld_d;
    logic                 out_sop_q,     out_sop_d;
    logic                 out_eop_q,     out_eop_d;
    logic                 out_abort_q,   out_abort_d;
    logic                 out_ch_q,      out_ch_d;
    logic [MAC_W-1:0]     out_src_mac_q, out_src_mac_d;
    logic [LEN_W-1:0]     out_len_q,     out_len_d;

    logic [HDR_SR_W-1:0]  hdr_shift;
    logic [MAC_W-1:0]     dst_mac;
    logic [15:0]          etype;
    logic                 dst_match;
    logic [LEN_W-1:0]     len_inc;
    logic                 acc_inc;
    logic                 drop_prev;
    logic                 drop_new;
    logic [1:0]           drop_inc;

    // Next-state and output decode; one frame-level decision per beat.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hdr_d         = hdr_q;
        mac_d         = mac_q;
        promisc_d     = promisc_q;
        len_d         = len_q;
        out_data_d    = out_data_q;
        out_ch_d      = out_ch_q;
        out_src_mac_d = out_src_mac_q;
        out_len_d     = out_len_q;
        out_vld_d     = 2'b00;
        out_sop_d     = 1'b0;
        out_eop_d     = 1'b0;
        out_abort_d   = 1'b0;
        acc_inc       = 1'b0;
        drop_prev     = 1'b0;
        drop_new      = 1'b0;

        // Header bytes are shifted in; the current byte completes each field.
        hdr_shift = {hdr_q[HDR_SR_W-9:0], rx.data};
        dst_mac   = {hdr_q[39:0], rx.data};
        etype     = {hdr_q[7:0], rx.data};
        dst_match = promisc_q | (dst_mac == mac_q) | (dst_mac == ETH_BCAST_MAC);
        len_inc   = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);

        if (Recv_Byte_Rdy) begin
            if (rx.sop) begin
                // Abandon any open frame; DROP frames were already counted.
                drop_prev   = (state_q == HDR) || (state_q == PAYLOAD);
                out_abort_d = (state_q == PAYLOAD);
                mac_d       = Mac_Addr;
                promisc_d   = Promisc;
                hdr_d       = hdr_shift;
                idx_d       = HDR_IDX_W'(1);
                if (rx.eop) begin
                    drop_new = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = HDR;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    HDR: begin
                        hdr_d = hdr_shift;
                        idx_d = idx_q + HDR_IDX_W'(1);
                        if (rx.eop) begin
                            drop_new = 1'b1;
                            state_d  = IDLE;
                        end else if (idx_q == IDX_DST_LAST && !dst_match) begin
                            drop_new = 1'b1;
                            state_d  = DROP;
                        end else if (idx_q == IDX_HDR_LAST) begin
                            if (etype == pETYPE_CH0 || etype == pETYPE_CH1) begin
                                out_ch_d      = (etype != pETYPE_CH0);
                                out_src_mac_d = hdr_q[HDR_SR_W-1:8];
                                len_d         = '0;
                                state_d       = PAYLOAD;
                            end else begin
                                drop_new = 1'b1;
                                state_d  = DROP;
                            end
                        end
                    end
                    PAYLOAD: begin
                        out_data_d = rx.data;
                        out_vld_d  = out_ch_q ? 2'b10 : 2'b01;
                        out_sop_d  = (len_q == '0);
                        len_d      = len_inc;
                        if (rx.eop) begin
                            out_eop_d = 1'b1;
                            out_len_d = len_inc;
                            acc_inc   = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    DROP: begin
                        if (rx.eop) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        drop_inc = {1'b0, drop_prev} + {1'b0, drop_new};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            hdr_q         <= '0;
            mac_q         <= '0;
            promisc_q     <= 1'b0;
            len_q         <= '0;
            out_data_q    <= '0;
            out_vld_q     <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_abort_q   <= 1'b0;
            out_ch_q      <= 1'b0;
            out_src_mac_q <= '0;
            out_len_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hdr_q         <= hdr_d;
            mac_q         <= mac_d;
            promisc_q     <= promisc_d;
            len_q         <= len_d;
            out_data_q    <= out_data_d;
            out_vld_q     <= out_vld_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_abort_q   <= out_abort_d;
            out_ch_q      <= out_ch_d;
            out_src_mac_q <= out_src_mac_d;
            out_len_q     <= out_len_d;
        end
    end

    eth_sat_cnt #(.W(pCNT_W)) u_acc_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (Cnt_Clr),
        .inc   ({1'b0, acc_inc}),
        .cnt   (Acc_Cnt)
    );

    eth_sat_cnt #(.W(pCNT_W)) u_drop_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (Cnt_Clr),
        .inc   (drop_inc),
        .cnt   (Drop_Cnt)
    );

    assign Out_Data    = out_data_q;
    assign Out_Vld     = out_vld_q;
    assign Out_Sop     = out_sop_q;
    assign Out_Eop     = out_eop_q;
    assign Out_Abort   = out_abort_q;
    assign Out_Ch      = out_ch_q;
    assign Out_Src_Mac = out_src_mac_q;
    assign Out_Len     = out_len_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Self-checking bench for eth_rx_dispatch. Frames are classified as whole
// byte lists (accept channel / drop) and turned into expected output events
// tagged with the cycle they must appear; a monitor collects the DUT events.
// A second instance with 4-bit counters exercises counter saturation.
module tb_eth_rx_dispatch;
    import eth_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [9:0]  recv_byte;
    logic        rdy;
    logic [47:0] mac_addr;
    logic        promisc;
    logic        cnt_clr;

    logic [7:0]  out_data;
    logic [1:0]  out_vld;
    logic        out_sop, out_eop, out_abort, out_ch;
    logic [47:0] out_src_mac;
    logic [10:0] out_len;
    logic [15:0] acc_cnt, drop_cnt;

    logic [7:0]  s_data;
    logic [1:0]  s_vld;
    logic        s_sop, s_eop, s_abort, s_ch;
    logic [47:0] s_src;
    logic [10:0] s_len;
    logic [3:0]  s_acc, s_drop;

    eth_rx_dispatch u_dut (
        .Clk(clk), .Rst_n(rst_n), .Recv_Byte(recv_byte), .Recv_Byte_Rdy(rdy),
        .Mac_Addr(mac_addr), .Promisc(promisc), .Cnt_Clr(cnt_clr),
        .Out_Data(out_data), .Out_Vld(out_vld), .Out_Sop(out_sop), .Out_Eop(out_eop),
        .Out_Abort(out_abort), .Out_Ch(out_ch), .Out_Src_Mac(out_src_mac),
        .Out_Len(out_len), .Acc_Cnt(acc_cnt), .Drop_Cnt(drop_cnt)
    );

    eth_rx_dispatch #(.pCNT_W(4)) u_dut_sat (
        .Clk(clk), .Rst_n(rst_n), .Recv_Byte(recv_byte), .Recv_Byte_Rdy(rdy),
        .Mac_Addr(mac_addr), .Promisc(promisc), .Cnt_Clr(cnt_clr),
        .Out_Data(s_data), .Out_Vld(s_vld), .Out_Sop(s_sop), .Out_Eop(s_eop),
        .Out_Abort(s_abort), .Out_Ch(s_ch), .Out_Src_Mac(s_src),
        .Out_Len(s_len), .Acc_Cnt(s_acc), .Drop_Cnt(s_drop)
    );

    typedef struct {
        int unsigned cyc;
        logic [1:0]  vld;
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic        abort;
        logic [10:0] len;
        logic [47:0] src;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         mon_ev;
    logic [7:0]  fb[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned m_acc = 0;
    int unsigned m_drop = 0;
    bit          pend_abort = 0;
    logic [47:0] pend_src = '0;
    bit          last_eop = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle on which the DUT shows any payload/abort activity.
    always @(negedge clk) begin
        if (rst_n && (out_vld != 2'b00 || out_abort || out_sop || out_eop)) begin
            mon_ev.cyc   = cyc;
            mon_ev.vld   = out_vld;
            mon_ev.data  = (out_vld != 2'b00) ? out_data : 8'h00;
            mon_ev.sop   = out_sop;
            mon_ev.eop   = out_eop;
            mon_ev.abort = out_abort;
            mon_ev.len   = out_eop ? out_len : 11'd0;
            mon_ev.src   = out_src_mac;
            obs_q.push_back(mon_ev);
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        rdy       = 1'b0;
        recv_byte = 10'($urandom);
        cnt_clr   = 1'b0;
    endtask

    // Non-SOP beat while idle: must be ignored.
    task automatic junk_beat();
        @(posedge clk);
        #1;
        rdy       = 1'b1;
        recv_byte = {1'b0, 9'($urandom)};
        cnt_clr   = 1'b0;
    endtask

    task automatic mk_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input int plen);
        fb.delete();
        for (int b = 0; b < 6; b++) fb.push_back(dst[47-8*b -: 8]);
        for (int b = 0; b < 6; b++) fb.push_back(src[47-8*b -: 8]);
        fb.push_back(et[15:8]);
        fb.push_back(et[7:0]);
        for (int b = 0; b < plen; b++) fb.push_back(8'($urandom));
    endtask

    // Drive fb as one frame and predict its outcome from the whole byte list.
    task automatic send_frame(input bit eop_end, input logic [47:0] mac, input bit prom,
                              input int gmin, input int gmax, input bit clr_last);
        int          n;
        int          ch;
        logic [47:0] dst, src;
        logic [15:0] et;
        ev_t         e;
        n   = fb.size();
        ch  = -1;
        src = '0;
        if (n >= ETH_HDR_LEN && !(n == ETH_HDR_LEN && eop_end)) begin
            dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
            src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
            et  = {fb[12], fb[13]};
            if (prom || dst == mac || dst == 48'hFFFF_FFFF_FFFF) begin
                if (et == 16'h0800) ch = 0;
                else if (et == 16'h0806) ch = 1;
            end
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmax, gmin)) idle_cycle();
            @(posedge clk);
            #1;
            rdy       = 1'b1;
            recv_byte = {i == 0, (i == n - 1) && eop_end, fb[i]};
            cnt_clr   = clr_last && (i == n - 1);
            if (i == 0) begin
                mac_addr = mac;
                promisc  = prom;
                if (pend_abort) begin
                    e.cyc = cyc + 1; e.vld = 2'b00; e.data = 8'h00; e.sop = 0;
                    e.eop = 0; e.abort = 1; e.len = 11'd0; e.src = pend_src;
                    exp_q.push_back(e);
                    pend_abort = 0;
                end
            end else begin
                mac_addr = {$urandom, 16'($urandom)};
                promisc  = 1'($urandom);
            end
            if (ch >= 0 && i >= ETH_HDR_LEN) begin
                e.cyc   = cyc + 1;
                e.vld   = (ch == 1) ? 2'b10 : 2'b01;
                e.data  = fb[i];
                e.sop   = (i == ETH_HDR_LEN);
                e.eop   = eop_end && (i == n - 1);
                e.abort = 0;
                e.len   = e.eop ? 11'(sat(n - ETH_HDR_LEN, 2047)) : 11'd0;
                e.src   = src;
                exp_q.push_back(e);
            end
        end
        if (ch >= 0 && eop_end) m_acc++;
        else m_drop++;
        if (ch >= 0 && !eop_end) begin
            pend_abort = 1;
            pend_src   = src;
        end
        if (clr_last) begin
            m_acc  = 0;
            m_drop = 0;
        end
        last_eop = eop_end;
    endtask

    task automatic check_events(input string tag);
        ev_t e, o;
        repeat (3) idle_cycle();
        chk_eq({tag, ":n_events"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk_eq({tag, ":cyc"},   64'(o.cyc),   64'(e.cyc));
            chk_eq({tag, ":vld"},   64'(o.vld),   64'(e.vld));
            chk_eq({tag, ":data"},  64'(o.data),  64'(e.data));
            chk_eq({tag, ":sop"},   64'(o.sop),   64'(e.sop));
            chk_eq({tag, ":eop"},   64'(o.eop),   64'(e.eop));
            chk_eq({tag, ":abort"}, 64'(o.abort), 64'(e.abort));
            chk_eq({tag, ":len"},   64'(o.len),   64'(e.len));
            chk_eq({tag, ":src"},   64'(o.src),   64'(e.src));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_counts(input string tag);
        chk_eq({tag, ":acc_cnt"},    64'(acc_cnt),  sat(m_acc, 16'hFFFF));
        chk_eq({tag, ":drop_cnt"},   64'(drop_cnt), sat(m_drop, 16'hFFFF));
        chk_eq({tag, ":acc_cnt4"},   64'(s_acc),    sat(m_acc, 15));
        chk_eq({tag, ":drop_cnt4"},  64'(s_drop),   sat(m_drop, 15));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, ":data"},  64'(out_data),    64'h0);
        chk_eq({tag, ":vld"},   64'(out_vld),     64'h0);
        chk_eq({tag, ":flags"}, 64'({out_sop, out_eop, out_abort, out_ch}), 64'h0);
        chk_eq({tag, ":src"},   64'(out_src_mac), 64'h0);
        chk_eq({tag, ":len"},   64'(out_len),     64'h0);
        chk_eq({tag, ":cnts"},  64'({acc_cnt, drop_cnt}), 64'h0);
    endtask

    localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] SRC_A     = 48'h00_11_22_33_44_55;

    initial begin
        logic [47:0] own;
        logic [47:0] dst;
        logic [15:0] et;
        int          r;
        bit          eop_end;

        rst_n = 1'b0; rdy = 1'b0; recv_byte = '0; mac_addr = '0; promisc = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_cycle();

        // IPv4 to own MAC, 46 payload bytes, back-to-back beats.
        mk_frame(MY_MAC, SRC_A, 16'h0800, 46);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        check_events("ipv4");
        check_counts("ipv4");

        // Broadcast ARP, 28 bytes, one beat every third cycle.
        mk_frame(ETH_BCAST_MAC, 48'hA0_B0_C0_D0_E0_F0, 16'h0806, 28);
        send_frame(1, MY_MAC, 0, 2, 2, 0);
        check_events("arp_gapped");
        check_counts("arp_gapped");

        // Foreign destination: dropped without Promisc, delivered with it.
        mk_frame(OTHER_MAC, SRC_A, 16'h0800, 20);
        send_frame(1, MY_MAC, 0, 0, 1, 0);
        mk_frame(OTHER_MAC, SRC_A, 16'h0800, 20);
        send_frame(1, MY_MAC, 1, 0, 1, 0);
        check_events("promisc");
        check_counts("promisc");

        // Unknown EtherType, a runt ending at header byte 10, then a good frame.
        mk_frame(MY_MAC, SRC_A, 16'h86DD, 20);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        mk_frame(MY_MAC, SRC_A, 16'h0800, 0);
        while (fb.size() > 11) void'(fb.pop_back());
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        mk_frame(MY_MAC, 48'h12_34_56_78_9A_BC, 16'h0806, 10);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        check_events("etype_runt");
        check_counts("etype_runt");

        // Missing EOP after 5 payload bytes, then a frame that must parse cleanly.
        mk_frame(MY_MAC, SRC_A, 16'h0800, 5);
        send_frame(0, MY_MAC, 0, 0, 0, 0);
        mk_frame(MY_MAC, 48'h66_77_88_99_AA_BB, 16'h0800, 12);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        check_events("abort");
        check_counts("abort");

        // One-byte runt (SOP and EOP together), then payload longer than 2047.
        fb.delete();
        fb.push_back(8'h5A);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        mk_frame(MY_MAC, SRC_A, 16'h0800, 2050);
        send_frame(1, MY_MAC, 0, 0, 0, 0);
        check_events("len_sat");
        check_counts("len_sat");

        // Randomized traffic; enough frames to saturate the 4-bit counters.
        for (int batch = 0; batch < 20; batch++) begin
            own = {8'h02, 40'($urandom)};
            for (int f = 0; f < 10; f++) begin
                if (last_eop && ($urandom_range(3, 0) == 0)) junk_beat();
                r = int'($urandom_range(3, 0));
                dst = (r == 1) ? ETH_BCAST_MAC : (r == 2) ? {8'h04, 40'($urandom)} : own;
                r = int'($urandom_range(4, 0));
                et = (r == 0 || r == 2) ? 16'h0800 : (r == 1 || r == 3) ? 16'h0806 : 16'($urandom);
                mk_frame(dst, {$urandom, 16'($urandom)}, et, int'($urandom_range(40, 0)));
                if ($urandom_range(7, 0) == 0) begin
                    r = int'($urandom_range(14, 1));
                    while (fb.size() > r) void'(fb.pop_back());
                end
                eop_end = (f == 9) || ($urandom_range(7, 0) != 0);
                send_frame(eop_end, own, $urandom_range(3, 0) == 0, 0, 2, 0);
            end
            check_events("random");
            check_counts("random");
        end

        // Counter clear on the same beat as an accepted EOP.
        mk_frame(MY_MAC, SRC_A, 16'h0806, 8);
        send_frame(1, MY_MAC, 0, 0, 0, 1);
        check_events("clr_eop");
        check_counts("clr_eop");

        // Reset asserted in the middle of a payload clears outputs at once.
        mk_frame(MY_MAC, SRC_A, 16'h0800, 6);
        send_frame(0, MY_MAC, 0, 0, 0, 0);
        check_events("pre_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_acc = 0; m_drop = 0; pend_abort = 0; last_eop = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs_q.delete();
        mk_frame(MY_MAC, 48'hDE_AD_BE_EF_00_01, 16'h0800, 9);
        send_frame(1, MY_MAC, 0, 0, 1, 0);
        check_events("post_reset");
        check_counts("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
